if_stage_pipe: RTL and testbench

//  Parametrised instruction-fetch stage with integrated IF/ID pipeline register.

---
 rtl/if_pkg.sv | 27 ++
 rtl/if_stage_pipe_if.sv | 39 +++
 rtl/if_imem.sv | 33 +++
 rtl/if_stage_pipe.sv | 134 +++++++++++++
 tb/tb_if_stage_pipe.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   DEF_*          default parameter values used by if_stage_pipe and its interface
//   fetch_state_e  fetch FSM states (RUN, HALT)
//   if_id_t        IF/ID slot payload at the default XLEN
package if_pkg;

   localparam int unsigned     DEF_XLEN       = 32;
   localparam int unsigned     DEF_IMEM_DEPTH = 256;
   localparam int unsigned     DEF_INSN_BYTES = 4;
   localparam int unsigned     DEF_CNT_W      = 32;
   localparam logic [31:0]     DEF_RESET_PC   = 32'h0000_0000;
   localparam logic [31:0]     DEF_NOP_INSN   = 32'h0000_0013;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [DEF_XLEN-1:0] pc;
      logic [DEF_XLEN-1:0] npc;
      logic [DEF_XLEN-1:0] insn;
      logic                valid;
      logic                fault;
   } if_id_t;

endpackage

// File: rtl/if_stage_pipe_if.sv
// Bus bundle between the fetch stage and its environment.
//   slave  : fetch-stage side (takes redirect/stall/IMEM load, drives IF/ID + status)
//   master : environment side (EX redirect, ID hazard, IMEM loader, decode)
interface if_stage_pipe_if #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned IMEM_DEPTH = 256,
   parameter int unsigned CNT_W      = 32
);
   localparam int unsigned AW = $clog2(IMEM_DEPTH);

   logic [XLEN-1:0]  ex_npc;
   logic             br_taken;
   logic             stall;
   logic             imem_we;
   logic [AW-1:0]    imem_waddr;
   logic [XLEN-1:0]  imem_wdata;

   logic [XLEN-1:0]  if_id_pc;
   logic [XLEN-1:0]  if_id_npc;
   logic [XLEN-1:0]  if_id_insn;
   logic             if_id_valid;
   logic             if_id_fault;
   logic [XLEN-1:0]  pc;
   logic             halted;
   logic [CNT_W-1:0] fetch_cnt;

   modport slave (
      input  ex_npc, br_taken, stall, imem_we, imem_waddr, imem_wdata,
      output if_id_pc, if_id_npc, if_id_insn, if_id_valid, if_id_fault,
             pc, halted, fetch_cnt
   );

   modport master (
      output ex_npc, br_taken, stall, imem_we, imem_waddr, imem_wdata,
      input  if_id_pc, if_id_npc, if_id_insn, if_id_valid, if_id_fault,
             pc, halted, fetch_cnt
   );

endinterface

// File: rtl/if_imem.sv
// Local instruction memory: DEPTH x XLEN words, asynchronous read, synchronous write.
//   clk    in  write clock
//   we     in  write enable
//   waddr  in  write word index
//   wdata  in  write data
//   raddr  in  read word index
//   rdata  out read data (combinational; same-edge write is seen only after the edge)
// Contents are deliberately not reset.
module if_imem #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 256
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [XLEN-1:0]          wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [XLEN-1:0]          rdata
);

   logic [XLEN-1:0] mem_q [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Read port
   assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_stage_pipe.sv
// Instruction-fetch stage with integrated IF/ID pipeline register.
//   clk   in  clock, all state on rising edge
//   rst   in  synchronous active-high reset
//   bus   slave modport of if_stage_pipe_if:
//         in  ex_npc, br_taken, stall, imem_we, imem_waddr, imem_wdata
//         out if_id_pc, if_id_npc, if_id_insn, if_id_valid, if_id_fault,
//             pc, halted, fetch_cnt
// Edge priority: rst > br_taken > stall > normal fetch. A faulting PC
// (misaligned or beyond IMEM) emits a fault slot and parks the FSM in HALT
// until a redirect or reset.
module if_stage_pipe
   import if_pkg::*;
#(
   parameter int unsigned     XLEN       = DEF_XLEN,
   parameter int unsigned     IMEM_DEPTH = DEF_IMEM_DEPTH,
   parameter int unsigned     INSN_BYTES = DEF_INSN_BYTES,
   parameter logic [XLEN-1:0] RESET_PC   = XLEN'(DEF_RESET_PC),
   parameter logic [XLEN-1:0] NOP_INSN   = XLEN'(DEF_NOP_INSN),
   parameter int unsigned     CNT_W      = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   if_stage_pipe_if.slave   bus
);

   localparam int unsigned AW    = $clog2(IMEM_DEPTH);
   localparam int unsigned OFF_W = $clog2(INSN_BYTES);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] npc;
      logic [XLEN-1:0] insn;
      logic            valid;
      logic            fault;
   } slot_t;

   logic [XLEN-1:0]  pc_q, pc_d;
   fetch_state_e     state_q, state_d;
   slot_t            if_id_q, if_id_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             halted_q, halted_d;

   logic [XLEN-1:0]  word_idx_c;
   logic [XLEN-1:0]  pc_inc_c;
   logic [XLEN-1:0]  rdata_c;
   logic             misalign_c;
   logic             oob_c;
   logic             fault_c;

   // Fetch address decode and fault detection
   assign word_idx_c = pc_q >> OFF_W;
   assign pc_inc_c   = pc_q + XLEN'(INSN_BYTES);
   assign misalign_c = |(pc_q & XLEN'(INSN_BYTES - 1));
   assign oob_c      = (word_idx_c >= XLEN'(IMEM_DEPTH));
   assign fault_c    = misalign_c | oob_c;

   if_imem #(
      .XLEN  (XLEN),
      .DEPTH (IMEM_DEPTH)
   ) u_imem (
      .clk   (clk),
      .we    (bus.imem_we),
      .waddr (bus.imem_waddr),
      .wdata (bus.imem_wdata),
      .raddr (word_idx_c[AW-1:0]),
      .rdata (rdata_c)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         state_q  <= RUN;
         if_id_q  <= '{pc: '0, npc: '0, insn: NOP_INSN, valid: 1'b0, fault: 1'b0};
         cnt_q    <= '0;
         halted_q <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         state_q  <= state_d;
         if_id_q  <= if_id_d;
         cnt_q    <= cnt_d;
         halted_q <= halted_d;
      end
   end

   // Next-PC mux, fetch FSM, IF/ID and counter update
   always_comb begin
      pc_d    = pc_q;
      state_d = state_q;
      if_id_d = if_id_q;
      cnt_d   = cnt_q;

      if (bus.br_taken) begin
         // Flush wins over stall and also recovers from HALT
         pc_d    = bus.ex_npc;
         state_d = RUN;
         if_id_d = '{pc: '0, npc: '0, insn: NOP_INSN, valid: 1'b0, fault: 1'b0};
      end else if (!bus.stall) begin
         unique case (state_q)
            RUN: begin
               if (fault_c) begin
                  if_id_d = '{pc: pc_q, npc: pc_inc_c, insn: NOP_INSN,
                              valid: 1'b0, fault: 1'b1};
                  state_d = HALT;
               end else begin
                  if_id_d = '{pc: pc_q, npc: pc_inc_c, insn: rdata_c,
                              valid: 1'b1, fault: 1'b0};
                  pc_d    = pc_inc_c;
                  cnt_d   = cnt_q + CNT_W'(1);
               end
            end
            HALT: begin
               if_id_d = '{pc: pc_q, npc: pc_inc_c, insn: NOP_INSN,
                           valid: 1'b0, fault: 1'b0};
            end
            default: begin
               state_d = RUN;
            end
         endcase
      end

      halted_d = (state_d == HALT);
   end

   assign bus.pc          = pc_q;
   assign bus.if_id_pc    = if_id_q.pc;
   assign bus.if_id_npc   = if_id_q.npc;
   assign bus.if_id_insn  = if_id_q.insn;
   assign bus.if_id_valid = if_id_q.valid;
   assign bus.if_id_fault = if_id_q.fault;
   assign bus.halted      = halted_q;
   assign bus.fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_if_stage_pipe.sv
// Directed, table-driven bench for if_stage_pipe (default parameters).
module tb_if_stage_pipe;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] NEWW = 32'hDEAD_BEEF;

   logic clk;
   logic rst;

   if_stage_pipe_if #(.XLEN(32), .IMEM_DEPTH(256), .CNT_W(32)) bus ();

   if_stage_pipe dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        br;
      logic [31:0] ex_npc;
      logic [31:0] e_pc;
      logic [31:0] e_ipc;
      logic [31:0] e_npc;
      logic [31:0] e_insn;
      logic        e_valid;
      logic        e_fault;
      logic        e_halted;
      logic [31:0] e_cnt;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_err = 0;

   function automatic logic [31:0] mw(input int i);
      return 32'hC0DE_0000 + 32'(i);
   endfunction

   function automatic vec_t mk(input logic st, input logic br, input logic [31:0] ex,
                               input logic [31:0] p, input logic [31:0] ip,
                               input logic [31:0] np, input logic [31:0] ins,
                               input logic v, input logic f, input logic h,
                               input logic [31:0] c);
      vec_t r;
      r.stall = st; r.br = br; r.ex_npc = ex;
      r.e_pc = p; r.e_ipc = ip; r.e_npc = np; r.e_insn = ins;
      r.e_valid = v; r.e_fault = f; r.e_halted = h; r.e_cnt = c;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
      end
   endtask

   task automatic check_all(input string tag, input logic [31:0] p, input logic [31:0] ip,
                            input logic [31:0] np, input logic [31:0] ins,
                            input logic v, input logic f, input logic h,
                            input logic [31:0] c);
      chk({tag, ".pc"},     bus.pc,                 p);
      chk({tag, ".if_pc"},  bus.if_id_pc,           ip);
      chk({tag, ".if_npc"}, bus.if_id_npc,          np);
      chk({tag, ".insn"},   bus.if_id_insn,         ins);
      chk({tag, ".valid"},  32'(bus.if_id_valid),   32'(v));
      chk({tag, ".fault"},  32'(bus.if_id_fault),   32'(f));
      chk({tag, ".halted"}, 32'(bus.halted),        32'(h));
      chk({tag, ".cnt"},    bus.fetch_cnt,          c);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      clk = 1'b0;
      rst = 1'b1;
      bus.ex_npc     = '0;
      bus.br_taken   = 1'b0;
      bus.stall      = 1'b0;
      bus.imem_we    = 1'b0;
      bus.imem_waddr = '0;
      bus.imem_wdata = '0;

      // Load IMEM while reset holds the fetch path idle
      for (int i = 0; i < 256; i++) begin
         bus.imem_we    = 1'b1;
         bus.imem_waddr = 8'(i);
         bus.imem_wdata = mw(i);
         step();
      end
      bus.imem_we = 1'b0;
      step();
      check_all("reset", 32'h0, 32'h0, 32'h0, NOP, 1'b0, 1'b0, 1'b0, 32'd0);
      rst = 1'b0;

      // stall br ex_npc | pc ipc npc insn v f h cnt
      vecs.push_back(mk(0,0,0,      32'h4,  32'h0,  32'h4,  mw(0), 1,0,0, 1));
      vecs.push_back(mk(0,0,0,      32'h8,  32'h4,  32'h8,  mw(1), 1,0,0, 2));
      vecs.push_back(mk(0,0,0,      32'hC,  32'h8,  32'hC,  mw(2), 1,0,0, 3));
      vecs.push_back(mk(0,0,0,      32'h10, 32'hC,  32'h10, mw(3), 1,0,0, 4));
      vecs.push_back(mk(1,0,0,      32'h10, 32'hC,  32'h10, mw(3), 1,0,0, 4));
      vecs.push_back(mk(1,0,0,      32'h10, 32'hC,  32'h10, mw(3), 1,0,0, 4));
      vecs.push_back(mk(1,0,0,      32'h10, 32'hC,  32'h10, mw(3), 1,0,0, 4));
      vecs.push_back(mk(0,0,0,      32'h14, 32'h10, 32'h14, mw(4), 1,0,0, 5));
      vecs.push_back(mk(1,1,32'h40, 32'h40, 32'h0,  32'h0,  NOP,   0,0,0, 5));
      vecs.push_back(mk(0,0,0,      32'h44, 32'h40, 32'h44, mw(16),1,0,0, 6));
      vecs.push_back(mk(0,1,32'h402,32'h402,32'h0,  32'h0,  NOP,   0,0,0, 6));
      vecs.push_back(mk(0,0,0,      32'h402,32'h402,32'h406,NOP,   0,1,1, 6));
      vecs.push_back(mk(0,0,0,      32'h402,32'h402,32'h406,NOP,   0,0,1, 6));
      vecs.push_back(mk(1,0,0,      32'h402,32'h402,32'h406,NOP,   0,0,1, 6));
      vecs.push_back(mk(0,1,32'h0,  32'h0,  32'h0,  32'h0,  NOP,   0,0,0, 6));
      vecs.push_back(mk(0,0,0,      32'h4,  32'h0,  32'h4,  mw(0), 1,0,0, 7));
      vecs.push_back(mk(0,1,32'h3F8,32'h3F8,32'h0,  32'h0,  NOP,   0,0,0, 7));
      vecs.push_back(mk(0,0,0,      32'h3FC,32'h3F8,32'h3FC,mw(254),1,0,0,8));
      vecs.push_back(mk(0,0,0,      32'h400,32'h3FC,32'h400,mw(255),1,0,0,9));
      vecs.push_back(mk(0,0,0,      32'h400,32'h400,32'h404,NOP,   0,1,1, 9));

      foreach (vecs[k]) begin
         bus.stall    = vecs[k].stall;
         bus.br_taken = vecs[k].br;
         bus.ex_npc   = vecs[k].ex_npc;
         step();
         check_all($sformatf("vec%0d", k), vecs[k].e_pc, vecs[k].e_ipc, vecs[k].e_npc,
                   vecs[k].e_insn, vecs[k].e_valid, vecs[k].e_fault,
                   vecs[k].e_halted, vecs[k].e_cnt);
      end
      bus.stall    = 1'b0;
      bus.br_taken = 1'b0;

      // Same-edge write and fetch of index 5: old word captured, new word next time
      bus.br_taken = 1'b1; bus.ex_npc = 32'h14;
      step();
      bus.br_taken = 1'b0;
      chk("redir5.pc", bus.pc, 32'h14);
      chk("redir5.halted", 32'(bus.halted), 32'd0);
      bus.imem_we = 1'b1; bus.imem_waddr = 8'd5; bus.imem_wdata = NEWW;
      step();
      bus.imem_we = 1'b0;
      check_all("wr_old", 32'h18, 32'h14, 32'h18, mw(5), 1'b1, 1'b0, 1'b0, 32'd10);
      bus.br_taken = 1'b1; bus.ex_npc = 32'h14;
      step();
      bus.br_taken = 1'b0;
      step();
      chk("wr_new.insn", bus.if_id_insn, NEWW);
      chk("wr_new.cnt", bus.fetch_cnt, 32'd11);

      // Reset out of HALT
      bus.br_taken = 1'b1; bus.ex_npc = 32'h402;
      step();
      bus.br_taken = 1'b0;
      step();
      chk("pre_rst.halted", 32'(bus.halted), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_all("rst_halt", 32'h0, 32'h0, 32'h0, NOP, 1'b0, 1'b0, 1'b0, 32'd0);

      // Reset during stall
      step();
      chk("post_rst.cnt", bus.fetch_cnt, 32'd1);
      bus.stall = 1'b1; rst = 1'b1;
      step();
      rst = 1'b0; bus.stall = 1'b0;
      check_all("rst_stall", 32'h0, 32'h0, 32'h0, NOP, 1'b0, 1'b0, 1'b0, 32'd0);

      // IMEM survives reset
      step();
      check_all("keep0", 32'h4, 32'h0, 32'h4, mw(0), 1'b1, 1'b0, 1'b0, 32'd1);
      bus.br_taken = 1'b1; bus.ex_npc = 32'h14;
      step();
      bus.br_taken = 1'b0;
      step();
      chk("keep5.insn", bus.if_id_insn, NEWW);
      chk("keep5.cnt", bus.fetch_cnt, 32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
